// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter/sequencer in front of the single-port data memory
module dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  output logic [1:0]    req_ready,
  input  logic          req_we0,
  input  logic          req_we1,
  input  logic          req_sign0,
  input  logic          req_sign1,
  input  logic [1:0]    req_size0,
  input  logic [1:0]    req_size1,
  input  logic [AW-1:0] req_addr0,
  input  logic [AW-1:0] req_addr1,
  input  logic [DW-1:0] req_wdata0,
  input  logic [DW-1:0] req_wdata1,
  output logic [1:0]    resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic          mem_WE,
  output logic          mem_ExtSign,
  output logic [1:0]    mem_MemSize,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_WD,
  input  logic [DW-1:0] mem_read
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic          last_grant;
  logic          grant;
  logic          hs;

  logic          owner_q;
  logic          we_q;
  logic          sign_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          err_q;
  logic [DW-1:0] rdata_q;

  logic          sel_we;
  logic          sel_sign;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_err;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not win last
  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) begin
      grant = ~last_grant;
    end
  end

  // Mux the granted requester's fields and pre-check alignment before anything reaches memory
  always_comb begin
    sel_we    = grant ? req_we1    : req_we0;
    sel_sign  = grant ? req_sign1  : req_sign0;
    sel_size  = grant ? req_size1  : req_size0;
    sel_addr  = grant ? req_addr1  : req_addr0;
    sel_wdata = grant ? req_wdata1 : req_wdata0;
    sel_err   = (sel_size == 2'b11) |
                ((sel_size == 2'b01) & sel_addr[0]) |
                ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00));
  end

  // Next-state and handshake/response strobes
  always_comb begin
    state_nx   = state;
    req_ready  = 2'b00;
    resp_valid = 2'b00;
    hs         = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready = grant ? 2'b10 : 2'b01;
          hs        = 1'b1;
          state_nx  = ACCESS;
        end
      end
      ACCESS: begin
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = owner_q ? 2'b10 : 2'b01;
        state_nx   = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Memory port is only live during ACCESS; reset kills the write enable immediately
  always_comb begin
    mem_WE      = 1'b0;
    mem_ExtSign = 1'b0;
    mem_MemSize = 2'b00;
    mem_addr    = '0;
    mem_WD      = '0;
    if (state == ACCESS) begin
      mem_WE      = we_q & ~err_q & ~rst;
      mem_ExtSign = sign_q;
      mem_MemSize = size_q;
      mem_addr    = addr_q;
      mem_WD      = wdata_q;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Remember the last winner so ties alternate; reset favours requester 0
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (hs) begin
      last_grant <= grant;
    end
  end

  // Capture the granted request so the requester is free to move on after the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q <= 1'b0;
      we_q    <= 1'b0;
      sign_q  <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (hs) begin
      owner_q <= grant;
      we_q    <= sel_we;
      sign_q  <= sel_sign;
      size_q  <= sel_size;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      err_q   <= sel_err;
    end
  end

  // Sample read data at the end of ACCESS; stores and errors return zero
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      rdata_q <= (!we_q && !err_q) ? mem_read : '0;
    end
  end

  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic        f_we[2];
  logic        f_sign[2];
  logic [1:0]  f_size[2];
  logic [31:0] f_addr[2];
  logic [31:0] f_wdata[2];
  logic [1:0]  resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_WE;
  logic        mem_ExtSign;
  logic [1:0]  mem_MemSize;
  logic [31:0] mem_addr;
  logic [31:0] mem_WD;
  logic [31:0] mem_read;

  int checks = 0;
  int errors = 0;
  int we_count = 0;

  logic [7:0]  mem [0:63];
  logic [7:0]  ref_mem [0:63];
  logic        pk_en = 1'b0;
  logic [5:0]  pk_addr = 6'd0;
  logic [31:0] pk_data = 32'd0;

  typedef struct {
    int          r;
    bit          we;
    bit          sign;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl[12];

  dmem_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we0(f_we[0]), .req_we1(f_we[1]),
    .req_sign0(f_sign[0]), .req_sign1(f_sign[1]),
    .req_size0(f_size[0]), .req_size1(f_size[1]),
    .req_addr0(f_addr[0]), .req_addr1(f_addr[1]),
    .req_wdata0(f_wdata[0]), .req_wdata1(f_wdata[1]),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_WE(mem_WE), .mem_ExtSign(mem_ExtSign), .mem_MemSize(mem_MemSize),
    .mem_addr(mem_addr), .mem_WD(mem_WD), .mem_read(mem_read)
  );

  always #5 clk = ~clk;

  // Little-endian byte memory with combinational, size/sign-aware read
  logic [5:0]  ma0, ma1, ma2, ma3;
  logic [15:0] mh;
  always_comb begin
    ma0 = mem_addr[5:0];
    ma1 = ma0 + 6'd1;
    ma2 = ma0 + 6'd2;
    ma3 = ma0 + 6'd3;
    mh  = {mem[ma1], mem[ma0]};
    case (mem_MemSize)
      2'd0:    mem_read = mem_ExtSign ? {{24{mem[ma0][7]}}, mem[ma0]} : {24'd0, mem[ma0]};
      2'd1:    mem_read = mem_ExtSign ? {{16{mh[15]}}, mh} : {16'd0, mh};
      2'd2:    mem_read = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
      default: mem_read = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (pk_en) begin
      mem[pk_addr]        <= pk_data[7:0];
      mem[pk_addr + 6'd1] <= pk_data[15:8];
      mem[pk_addr + 6'd2] <= pk_data[23:16];
      mem[pk_addr + 6'd3] <= pk_data[31:24];
    end else if (mem_WE) begin
      we_count <= we_count + 1;
      mem[ma0] <= mem_WD[7:0];
      if (mem_MemSize != 2'd0) mem[ma1] <= mem_WD[15:8];
      if (mem_MemSize == 2'd2) begin
        mem[ma2] <= mem_WD[23:16];
        mem[ma3] <= mem_WD[31:24];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    pk_en = 1'b1;
    pk_addr = a[5:0];
    pk_data = d;
    @(posedge clk);
    #1 pk_en = 1'b0;
  endtask

  function automatic logic [31:0] peek_word(input int a);
    return {mem[a + 3], mem[a + 2], mem[a + 1], mem[a]};
  endfunction

  function automatic logic [31:0] ref_load(input int a, input int size, input bit sign);
    int n;
    logic [31:0] v;
    n = 1 << size;
    v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_mem[(a + k) % 64]) << (8 * k));
    if (sign && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input int a, input int size, input logic [31:0] d);
    for (int k = 0; k < (1 << size); k++) ref_mem[(a + k) % 64] = 8'(d >> (8 * k));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 2'b00;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int i, input bit we, input bit sign, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
    f_we[i] = we;
    f_sign[i] = sign;
    f_size[i] = size;
    f_addr[i] = addr;
    f_wdata[i] = wdata;
  endtask

  task automatic rand_fields(input int i);
    logic [31:0] a;
    a = $urandom_range(0, 63);
    if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
    set_req(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a, $urandom);
  endtask

  // One complete isolated transaction with cycle-by-cycle checks
  task automatic do_txn(input int idx, input vec_t v);
    int base;
    bit got;
    logic [1:0] own;
    own = (v.r == 1) ? 2'b10 : 2'b01;
    base = we_count;
    set_req(v.r, v.we, v.sign, v.size, v.addr, v.wdata);
    req_valid = own;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req_ready != 2'b00) got = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      chk($sformatf("tbl%0d timeout", idx), 32'd0, 32'd1);
      req_valid = 2'b00;
      return;
    end
    chk($sformatf("tbl%0d ready", idx), 32'(req_ready), 32'(own));
    @(posedge clk);
    #1 req_valid = 2'b00;
    @(negedge clk);
    chk($sformatf("tbl%0d mem_addr", idx), mem_addr, v.addr);
    chk($sformatf("tbl%0d mem_WE", idx), 32'(mem_WE), 32'(v.we && !v.err));
    chk($sformatf("tbl%0d mem_MemSize", idx), 32'(mem_MemSize), 32'(v.size));
    chk($sformatf("tbl%0d mem_ExtSign", idx), 32'(mem_ExtSign), 32'(v.sign));
    @(posedge clk);
    #1;
    @(negedge clk);
    chk($sformatf("tbl%0d resp_valid", idx), 32'(resp_valid), 32'(own));
    chk($sformatf("tbl%0d resp_err", idx), 32'(resp_err), 32'(v.err));
    chk($sformatf("tbl%0d resp_rdata", idx), resp_rdata, v.rdata);
    @(posedge clk);
    #1;
    chk($sformatf("tbl%0d write_count", idx), 32'(we_count - base), 32'(v.we && !v.err));
  endtask

  initial begin
    int order[$];
    int own_q[$];
    int hs_t[$];
    int dual;
    int base;
    int m_last, hs_c, t_own, win, drop;
    bit t_we, t_err, got;
    logic [1:0] exp_rdy;
    logic [31:0] t_addr, t_rd;

    for (int i = 0; i < 2; i++) set_req(i, 1'b0, 1'b0, 2'd2, 32'd0, 32'd0);

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst mem_WE", 32'(mem_WE), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'd0);
    chk("rst resp_err", 32'(resp_err), 32'd0);
    @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    chk("rst tie grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    for (int a = 0; a < 64; a += 4) poke(a, 32'd0);
    poke(4, 32'h1122_3344);
    poke(8, 32'hDEAD_BEEF);

    tbl[0]  = '{0, 0, 0, 2'd2, 32'h8, 32'h0,         0, 32'hDEAD_BEEF};
    tbl[1]  = '{1, 1, 0, 2'd0, 32'h5, 32'hAAAA_AA80, 0, 32'h0};
    tbl[2]  = '{0, 0, 1, 2'd0, 32'h5, 32'h0,         0, 32'hFFFF_FF80};
    tbl[3]  = '{0, 0, 0, 2'd0, 32'h5, 32'h0,         0, 32'h0000_0080};
    tbl[4]  = '{0, 1, 0, 2'd2, 32'h6, 32'h1234_5678, 1, 32'h0};
    tbl[5]  = '{0, 1, 0, 2'd3, 32'h4, 32'h1234_5678, 1, 32'h0};
    tbl[6]  = '{1, 0, 0, 2'd2, 32'h4, 32'h0,         0, 32'h1122_8044};
    tbl[7]  = '{0, 0, 1, 2'd1, 32'h8, 32'h0,         0, 32'hFFFF_BEEF};
    tbl[8]  = '{1, 0, 0, 2'd1, 32'h9, 32'h0,         1, 32'h0};
    tbl[9]  = '{1, 0, 0, 2'd1, 32'hA, 32'h0,         0, 32'h0000_DEAD};
    tbl[10] = '{0, 1, 0, 2'd1, 32'hC, 32'h5555_7FFE, 0, 32'h0};
    tbl[11] = '{1, 0, 1, 2'd1, 32'hC, 32'h0,         0, 32'h0000_7FFE};
    for (int i = 0; i < 12; i++) do_txn(i, tbl[i]);

    // Tie: both held valid, grants alternate starting with requester 0
    do_reset();
    set_req(0, 1'b0, 1'b0, 2'd2, 32'h8, 32'h0);
    set_req(1, 1'b0, 1'b0, 2'd2, 32'h4, 32'h0);
    req_valid = 2'b11;
    dual = 0;
    for (int k = 0; k < 40 && (order.size() < 4 || own_q.size() > 0); k++) begin
      @(negedge clk);
      if (req_ready == 2'b11) dual++;
      if (resp_valid != 2'b00) begin
        if (own_q.size() == 0) chk("tie stray resp", 32'(resp_valid), 32'd0);
        else begin
          t_own = own_q.pop_front();
          chk("tie resp owner", 32'(resp_valid), (t_own == 1) ? 32'd2 : 32'd1);
          chk("tie resp rdata", resp_rdata, (t_own == 1) ? 32'h1122_8044 : 32'hDEAD_BEEF);
        end
      end
      got = 1'b0;
      if (req_ready != 2'b00 && order.size() < 4) begin
        order.push_back(int'(req_ready[1]));
        own_q.push_back(int'(req_ready[1]));
        got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got && order.size() == 4) req_valid = 2'b00;
    end
    req_valid = 2'b00;
    chk("tie count", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size(); i++) chk($sformatf("tie order%0d", i), 32'(order[i]), 32'(i % 2));
    chk("tie never both ready", 32'(dual), 32'd0);

    // Back-to-back: requester 1 holds valid through its own response
    repeat (3) @(posedge clk);
    #1;
    set_req(1, 1'b0, 1'b0, 2'd2, 32'h8, 32'h0);
    req_valid = 2'b10;
    for (int k = 0; k < 30 && hs_t.size() < 3; k++) begin
      @(negedge clk);
      if (req_ready == 2'b10) hs_t.push_back(k);
      @(posedge clk);
      #1;
    end
    req_valid = 2'b00;
    chk("b2b count", 32'(hs_t.size()), 32'd3);
    for (int i = 1; i < hs_t.size(); i++) chk($sformatf("b2b spacing%0d", i), 32'(hs_t[i] - hs_t[i-1]), 32'd3);

    // Reset during ACCESS of a store: no write, no response, fresh tie goes to 0
    repeat (4) @(posedge clk);
    #1;
    poke(16, 32'd0);
    base = we_count;
    set_req(0, 1'b1, 1'b0, 2'd2, 32'h10, 32'hCAFE_F00D);
    req_valid = 2'b01;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      if (req_ready == 2'b01) got = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("rstmid handshake", 32'(got), 32'd1);
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid mem_WE", 32'(mem_WE), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rstmid resp_valid hold", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    dual = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (resp_valid != 2'b00) dual++;
      @(posedge clk);
      #1;
    end
    chk("rstmid no resp", 32'(dual), 32'd0);
    chk("rstmid mem word", peek_word(16), 32'd0);
    chk("rstmid write_count", 32'(we_count - base), 32'd0);
    req_valid = 2'b11;
    @(negedge clk);
    chk("rstmid tie grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 2'b00;

    // Randomised traffic against a transaction-level model
    do_reset();
    for (int a = 0; a < 64; a++) ref_mem[a] = mem[a];
    m_last = 1;
    hs_c = -10;
    t_own = 0; t_we = 0; t_err = 0; t_addr = 0; t_rd = 0;
    drop = -1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      if (drop >= 0) req_valid[drop] = 1'b0;
      drop = -1;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rand_fields(i);
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 3) == 0) rand_fields(i);
      end
      @(negedge clk);
      exp_rdy = 2'b00;
      win = 0;
      if ((c - hs_c) >= 3 && req_valid != 2'b00) begin
        win = (req_valid == 2'b11) ? (1 - m_last) : (req_valid[1] ? 1 : 0);
        exp_rdy = (win == 1) ? 2'b10 : 2'b01;
      end
      chk("rnd req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rnd mem_WE", 32'(mem_WE), 32'(c == hs_c + 1 && t_we && !t_err));
      chk("rnd mem_addr", mem_addr, (c == hs_c + 1) ? t_addr : 32'd0);
      chk("rnd resp_valid", 32'(resp_valid), (c == hs_c + 2) ? ((t_own == 1) ? 32'd2 : 32'd1) : 32'd0);
      if (c == hs_c + 2) begin
        chk("rnd resp_err", 32'(resp_err), 32'(t_err));
        chk("rnd resp_rdata", resp_rdata, t_rd);
      end
      if (exp_rdy != 2'b00) begin
        hs_c = c;
        m_last = win;
        t_own = win;
        t_we = f_we[win];
        t_addr = f_addr[win];
        t_err = (f_size[win] == 2'd3) ||
                (f_size[win] == 2'd1 && (f_addr[win] % 2) != 0) ||
                (f_size[win] == 2'd2 && (f_addr[win] % 4) != 0);
        t_rd = 32'd0;
        if (!t_err && !t_we) t_rd = ref_load(int'(f_addr[win]), int'(f_size[win]), f_sign[win]);
        if (!t_err && t_we) ref_store(int'(f_addr[win]), int'(f_size[win]), f_wdata[win]);
        drop = win;
      end
    end
    @(posedge clk);
    #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    for (int a = 0; a < 64; a++) chk($sformatf("rnd mem byte %0d", a), 32'(mem[a]), 32'(ref_mem[a]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
